// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT
  } cap_state_t;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STAT    = 2'd1;
  localparam logic [1:0] ADDR_BAUD_LO = 2'd2;
  localparam logic [1:0] ADDR_BAUD_HI = 2'd3;

  localparam int STAT_OVF   = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;

  localparam logic [12:0] BAUD_DEFAULT = 13'd5208;

  function automatic logic [7:0] status_byte(input logic ovf, input logic full,
                                             input logic empty, input logic [3:0] count);
    logic [7:0] s;
    s             = 8'h00;
    s[STAT_OVF]   = ovf;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[3:0]        = count;
    return s;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous byte FIFO; a push into a full FIFO is accepted only when a pop frees the slot.
module rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [3:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == 4'd0);
  assign full    = (count == 4'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= 4'd0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + PW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + PW'(1);
      end
      count <= count + 4'(push_ok) - 4'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Bus-side UART receive controller: baud divisor, clr_rdy handshake, receive FIFO, status.
// Optional interrupt output enabled by defining RX_CTRL_IRQ_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [12:0] BAUD_RST   = BAUD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iocs,
  input  logic        iorw,
  input  logic [1:0]  ioaddr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rdy,
  output logic [12:0] baud_rate,
  output logic        rda,
  output logic        ovf
`ifdef RX_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  cap_state_t state;
  logic [7:0] baud_lo;
  logic       rd;
  logic       wr;
  logic       pop;
  logic       push;
  logic       ovf_set;
  logic       ovf_clr;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] fifo_count;

  assign rd      = iocs && iorw;
  assign wr      = iocs && !iorw;
  assign pop     = rd && (ioaddr == ADDR_DATA);
  assign push    = (state == IDLE) && rx_rdy;
  assign ovf_set = push && fifo_full && !pop;
  assign ovf_clr = wr && (ioaddr == ADDR_STAT) && wdata[7];
  assign rda     = !fifo_empty;

  rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (rx_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // WAIT holds until rx_rdy drops so a level-style ready is captured once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clr_rdy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            state   <= ACK;
            clr_rdy <= 1'b1;
          end
        end
        ACK: begin
          state   <= WAIT;
          clr_rdy <= 1'b0;
        end
        WAIT: begin
          if (!rx_rdy) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          clr_rdy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf       <= 1'b0;
      rdata     <= 8'h00;
      baud_rate <= BAUD_RST;
      baud_lo   <= BAUD_RST[7:0];
    end else begin
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end

      if (rd) begin
        case (ioaddr)
          ADDR_DATA: rdata <= fifo_empty ? 8'h00 : fifo_dout;
          ADDR_STAT: rdata <= status_byte(ovf, fifo_full, fifo_empty, fifo_count);
          default: ;
        endcase
      end

      // The high write commits both halves so the divisor never shows a torn value.
      if (wr) begin
        case (ioaddr)
          ADDR_BAUD_LO: baud_lo   <= wdata;
          ADDR_BAUD_HI: baud_rate <= {wdata[4:0], baud_lo};
          default: ;
        endcase
      end
    end
  end

`ifdef RX_CTRL_IRQ_EN
  logic irq_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr && (ioaddr == ADDR_STAT)) begin
        irq_mask <= wdata[0];
      end
      irq <= irq_mask && (rda || ovf);
    end
  end
`endif

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Bus-side controller for the UART receiver. It programs the receiver's 13-bit baud divisor, acknowledges each received byte through the receiver's `clr_rdy` handshake, and buffers bytes in a small FIFO. A processor reads data and status through a 2-bit register map. It sits between the receiver and the processor's I/O bus, one instance per receiver.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of two, 2 to 8.
- `BAUD_RST`, default 13'd5208: baud divisor loaded at reset (50 MHz clock, 9600 baud).

Ports:
- `clk`, input, 1: the single clock; every register updates on its rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `iocs`, input, 1: bus chip-select strobe; one access per high cycle.
- `iorw`, input, 1: 1 = read, 0 = write; qualified by `iocs`.
- `ioaddr`, input, 2: register address.
- `wdata`, input, 8: write data.
- `rdata`, output, 8: registered read data.
- `rx_data`, input, 8: byte from the receiver.
- `rx_rdy`, input, 1: receiver byte-ready; treated as a level or a pulse.
- `clr_rdy`, output, 1: one-cycle acknowledge to the receiver.
- `baud_rate`, output, 13: divisor driven to the receiver.
- `rda`, output, 1: receive data available (FIFO not empty).
- `ovf`, output, 1: sticky overflow flag.
- `irq`, output, 1: present only with `RX_CTRL_IRQ_EN`.

## Operation
Register map:
- Address 0, read: pop the FIFO head into `rdata`. If the FIFO is empty, `rdata` = 8'h00 and the pointers do not move.
- Address 1, read: status = {`ovf`, full, empty, 1'b0, count[3:0]}.
- Address 1, write: bit 7 = 1 clears `ovf`. Bit 0 is the irq mask when `RX_CTRL_IRQ_EN` is defined; otherwise bit 0 is ignored.
- Address 2, write: load the shadow low byte only; `baud_rate` does not change.
- Address 3, write: commit `baud_rate` = {`wdata`[4:0], shadow}. This makes the 13-bit update atomic. `wdata`[7:5] are ignored.
- Any other access has no effect and does not change `rdata`.

Capture FSM (states in the shared package):
- IDLE:
  - Stays in IDLE while `rx_rdy` = 0.
  - When `rx_rdy` = 1, pushes `rx_data` on that edge and goes to ACK.
  - If the FIFO is full and no pop occurs in the same cycle: the byte is dropped and `ovf` is set. The state still goes to ACK.
- ACK: `clr_rdy` = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - Stays in WAIT while `rx_rdy` = 1, so a held level is never captured twice.
  - Returns to IDLE when `rx_rdy` = 0.

FIFO:
- Count width is 4 bits. Read and write pointers wrap modulo `FIFO_DEPTH`.
- Push and pop in the same cycle:
  - FIFO non-empty: both succeed and the count is unchanged.
  - FIFO full: the pop frees the slot, so the push succeeds and `ovf` is not set.
  - FIFO empty: the push succeeds, and the pop returns 8'h00.
- `rda` = !empty. It is derived from the registered count, so there is no combinational path from inputs.

`ovf` priority: if an overflow and an `ovf`-clear write occur in the same cycle, set wins.

## Timing
Values after reset:
- State IDLE, FIFO empty, count = 0.
- `baud_rate` = `BAUD_RST`; shadow low byte = `BAUD_RST`[7:0].
- `rdata`, `clr_rdy`, `rda`, `ovf`, `irq` = 0; irq mask = 0.

Reset asserted mid-operation returns all state to the values above on the next edge. A byte not yet pushed is lost; buffered bytes are discarded.

Latencies:
- Capture: `rx_rdy` high in cycle N (state IDLE) gives push at the end of cycle N, with `rda` = 1 and `clr_rdy` = 1 in cycle N+1.
- The earliest next capture is cycle N+3 (IDLE in N+3, provided `rx_rdy` is low in N+2).
- Read: strobe in cycle N gives `rdata` valid in N+1. The pop and count update are visible in N+1.
- Baud commit: write to address 3 in cycle N gives the new `baud_rate` in N+1.

## Configuration
- `RX_CTRL_IRQ_EN` defined: adds output `irq` = mask & (`rda` | `ovf`), registered, so it follows `rda`/`ovf` by one cycle. The mask is written through status bit 0.
- `RX_CTRL_IRQ_EN` undefined: no `irq` port and no mask register; status-write bit 0 is ignored.

## Structure
- Package `uart_pkg` holds:
  - the capture-state enum (IDLE, ACK, WAIT);
  - register address localparams (ADDR_DATA = 0, ADDR_STAT = 1, ADDR_BAUD_LO = 2, ADDR_BAUD_HI = 3);
  - the status bit positions;
  - the default divisor constant.
- One sub-module, `rx_fifo`: a synchronous FIFO parameterized by depth, with push, pop, dout, full, empty and count.
- The FSM, the register decode and the baud shadow register live in `uart_rx_ctrl`.

## Test plan
- Reset, then read status and the data register -> status = 8'h20 (empty), `rdata` = 8'h00, `baud_rate` = 5208.
- Write 8'h58 to address 2, then 8'h01 to address 3 -> `baud_rate` = 13'h158 one cycle after the second write and unchanged after the first.
- `rx_rdy` held high for 5 cycles with `rx_data` = 8'hA5 -> exactly one push, one `clr_rdy` pulse in cycle N+1, status count = 1, data read returns 8'hA5 and `rda` then falls.
- Five bytes 01..05 with `FIFO_DEPTH` = 4 and no reads -> `ovf` = 1, status = 8'hC4, reads return 01,02,03,04, and writing 8'h80 to address 1 clears `ovf`.
- FIFO full, with a push and a data read in the same cycle -> the read returns the oldest byte, count stays 4, `ovf` stays 0.
- `RX_CTRL_IRQ_EN` defined: write 8'h01 to status, then receive one byte -> `irq` rises one cycle after `rda`, and falls one cycle after the byte is read.
